// File: rtl/ce_frame_ctrl_if.sv
// Handshake and strobe bundle between the sample front end, the frame
// sequencer and the CE core.
interface ce_frame_ctrl_if #(
   parameter int unsigned CNT_W = 8
);
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic             ce_clear;
   logic             ce_pilot_en;
   logic             ce_est_load;
   logic             ce_apply_en;
   logic [CNT_W-1:0] sym_idx;
   logic             busy;
   logic             frame_done;
   logic             err_overrun;

   // Side that issues frame starts and samples, and watches the strobes.
   modport master (
      output start,
      output in_valid,
      input  in_ready,
      input  ce_clear,
      input  ce_pilot_en,
      input  ce_est_load,
      input  ce_apply_en,
      input  sym_idx,
      input  busy,
      input  frame_done,
      input  err_overrun
   );

   // Frame sequencer side.
   modport slave (
      input  start,
      input  in_valid,
      output in_ready,
      output ce_clear,
      output ce_pilot_en,
      output ce_est_load,
      output ce_apply_en,
      output sym_idx,
      output busy,
      output frame_done,
      output err_overrun
   );
endinterface

// File: rtl/ce_frame_ctrl.sv
// CE frame sequencer: clear -> pilot accumulation -> estimate latch -> data
// equalization -> done. All outputs come from registers; only the pilot/apply
// enables are qualified combinationally with in_valid.
module ce_frame_ctrl #(
   parameter int unsigned PILOT_LEN  = 16,
   parameter int unsigned DATA_LEN   = 64,
   parameter int unsigned CE_LATENCY = 4,
   parameter int unsigned CNT_W      = 8
) (
   input logic             clk,
   input logic             reset,
   ce_frame_ctrl_if.slave  io_bus
);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StPilot,
      StWait,
      StData,
      StDone
   } state_t;

   // Terminal values; a length of 2^CNT_W becomes all-ones and the counter
   // returns to zero on the exit beat.
   localparam logic [CNT_W-1:0] PilotLast = CNT_W'(PILOT_LEN - 1);
   localparam logic [CNT_W-1:0] DataLast  = CNT_W'(DATA_LEN - 1);
   localparam logic [CNT_W-1:0] LatLoad   = CNT_W'(CE_LATENCY - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_lat;
   logic             r_in_ready;
   logic             r_pilot_ph;
   logic             r_data_ph;
   logic             r_clear;
   logic             r_est_load;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic             w_beat;
   logic             w_in_frame;

   assign w_beat     = io_bus.in_valid & r_in_ready;
   assign w_in_frame = (r_state == StClear) || (r_state == StPilot) ||
                       (r_state == StWait)  || (r_state == StData);

   // Frame FSM with registered strobes and phase flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_lat      <= '0;
         r_in_ready <= 1'b0;
         r_pilot_ph <= 1'b0;
         r_data_ph  <= 1'b0;
         r_clear    <= 1'b0;
         r_est_load <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_clear    <= 1'b0;
         r_est_load <= 1'b0;
         r_done     <= 1'b0;
         // A start mid-frame is dropped but remembered until reset.
         if (io_bus.start && w_in_frame) begin
            r_err <= 1'b1;
         end
         case (r_state)
            StIdle: begin
               if (io_bus.start) begin
                  r_state <= StClear;
                  r_clear <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            StClear: begin
               r_state    <= StPilot;
               r_cnt      <= '0;
               r_in_ready <= 1'b1;
               r_pilot_ph <= 1'b1;
            end
            StPilot: begin
               if (w_beat) begin
                  if (r_cnt == PilotLast) begin
                     r_state    <= StWait;
                     r_cnt      <= '0;
                     r_lat      <= LatLoad;
                     r_in_ready <= 1'b0;
                     r_pilot_ph <= 1'b0;
                     // Single-cycle latency: the only WAIT cycle is the load cycle.
                     r_est_load <= (LatLoad == '0);
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            StWait: begin
               if (r_lat == '0) begin
                  r_state    <= StData;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b1;
                  r_data_ph  <= 1'b1;
               end else begin
                  r_lat      <= r_lat - 1'b1;
                  r_est_load <= (r_lat == CNT_W'(1));
               end
            end
            StData: begin
               if (w_beat) begin
                  if (r_cnt == DataLast) begin
                     r_state    <= StDone;
                     r_cnt      <= '0;
                     r_in_ready <= 1'b0;
                     r_data_ph  <= 1'b0;
                     r_done     <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            StDone: begin
               if (io_bus.start) begin
                  r_state <= StClear;
                  r_clear <= 1'b1;
               end else begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state    <= StIdle;
               r_cnt      <= '0;
               r_in_ready <= 1'b0;
               r_pilot_ph <= 1'b0;
               r_data_ph  <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.in_ready    = r_in_ready;
   assign io_bus.ce_clear    = r_clear;
   assign io_bus.ce_pilot_en = r_pilot_ph & io_bus.in_valid;
   assign io_bus.ce_est_load = r_est_load;
   assign io_bus.ce_apply_en = r_data_ph & io_bus.in_valid;
   assign io_bus.sym_idx     = r_cnt;
   assign io_bus.busy        = r_busy;
   assign io_bus.frame_done  = r_done;
   assign io_bus.err_overrun = r_err;

endmodule

// File: tb/tb_ce_frame_ctrl.sv
// Scoreboard bench for ce_frame_ctrl: stimulus pushes hand-computed strobe
// events (kind, sym_idx, cycle); negedge monitors pop and compare them.
module tb_ce_frame_ctrl;

   localparam int P0 = 16;
   localparam int L0 = 4;
   localparam int D0 = 64;
   localparam int P1 = 1;
   localparam int L1 = 1;
   localparam int D1 = 256;
   localparam int NoAbort = 100000;

   // Event kinds
   localparam int KClear = 0;
   localparam int KPilot = 1;
   localparam int KEst   = 2;
   localparam int KApply = 3;
   localparam int KDone  = 4;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ce_frame_ctrl_if #(.CNT_W(8)) if0 ();
   ce_frame_ctrl_if #(.CNT_W(8)) if1 ();

   ce_frame_ctrl #(
      .PILOT_LEN (P0),
      .DATA_LEN  (D0),
      .CE_LATENCY(L0),
      .CNT_W     (8)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .io_bus(if0.slave)
   );

   ce_frame_ctrl #(
      .PILOT_LEN (P1),
      .DATA_LEN  (D1),
      .CE_LATENCY(L1),
      .CNT_W     (8)
   ) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .io_bus(if1.slave)
   );

   typedef struct {
      int kind;
      int idx;
      int cyc;
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int inst, input int kind, input int idx, input int c,
                       input int lim);
      ev_t e;
      if (c >= lim) return;
      e.kind = kind;
      e.idx  = idx;
      e.cyc  = c;
      if (inst == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // Compare whatever strobe the DUT shows this cycle against the queue head.
   task automatic mon(input int inst, input logic c, input logic p, input logic e,
                      input logic a, input logic d, input int idx);
      int  nset;
      int  kind;
      ev_t x;
      nset = int'(c) + int'(p) + int'(e) + int'(a) + int'(d);
      if (nset == 0) return;
      if (nset > 1) chk($sformatf("inst%0d_one_strobe", inst), nset, 1);
      kind = c ? KClear : p ? KPilot : e ? KEst : a ? KApply : KDone;
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
         n_checks++;
         n_errors++;
         $display("FAIL inst%0d_unexpected_strobe: got kind %0d idx %0d, expected none (cycle %0d)",
                  inst, kind, idx, cyc);
         return;
      end
      if (inst == 0) x = q0.pop_front();
      else x = q1.pop_front();
      chk($sformatf("inst%0d_kind", inst), kind, x.kind);
      chk($sformatf("inst%0d_sym_idx", inst), idx, x.idx);
      chk($sformatf("inst%0d_cycle", inst), cyc, x.cyc);
   endtask

   always @(negedge clk) begin
      mon(0, if0.ce_clear, if0.ce_pilot_en, if0.ce_est_load, if0.ce_apply_en,
          if0.frame_done, int'(if0.sym_idx));
      mon(1, if1.ce_clear, if1.ce_pilot_en, if1.ce_est_load, if1.ce_apply_en,
          if1.frame_done, int'(if1.sym_idx));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int inst, input logic st, input logic v);
      if (inst == 0) begin
         if0.start    = st;
         if0.in_valid = v;
      end else begin
         if1.start    = st;
         if1.in_valid = v;
      end
   endtask

   task automatic get(input int inst, output int busy, output int rdy, output int err);
      busy = (inst == 0) ? int'(if0.busy) : int'(if1.busy);
      rdy  = (inst == 0) ? int'(if0.in_ready) : int'(if1.in_ready);
      err  = (inst == 0) ? int'(if0.err_overrun) : int'(if1.err_overrun);
   endtask

   // Idle cycles with in_valid high: nothing may be counted or strobed.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 1'b0, 1'b1);
         drive(1, 1'b0, 1'b1);
         step();
      end
   endtask

   // Cycle 0 is the cycle start is presented (sampled at its closing edge).
   // Returns positioned inside the DONE cycle, or asserts reset at abort_k.
   task automatic frame(input int inst, input bit stall, input int ovr_k, input int abort_k);
      int p, l, d, b, lim, done_k, n, busy, rdy, err;
      p   = (inst == 0) ? P0 : P1;
      l   = (inst == 0) ? L0 : L1;
      d   = (inst == 0) ? D0 : D1;
      b   = cyc;
      lim = b + abort_k;
      push(inst, KClear, 0, b + 1, lim);
      if (stall) begin
         // in_valid only in even cycles: pilots 2,4..32; est 36; data 38,40..164; done 165
         for (int k = 0; k < p; k++) push(inst, KPilot, k, b + 2 + 2 * k, lim);
         push(inst, KEst, 0, b + 2 * p + l, lim);
         for (int k = 0; k < d; k++) push(inst, KApply, k, b + 2 * p + l + 2 + 2 * k, lim);
         done_k = 2 * p + l + 2 * d + 1;
      end else begin
         for (int k = 0; k < p; k++) push(inst, KPilot, k, b + 2 + k, lim);
         push(inst, KEst, 0, b + p + l + 1, lim);
         for (int k = 0; k < d; k++) push(inst, KApply, k, b + p + l + 2 + k, lim);
         done_k = p + l + d + 2;
      end
      push(inst, KDone, 0, b + done_k, lim);
      n = (abort_k < done_k) ? abort_k : done_k;
      for (int k = 0; k < n; k++) begin
         if (k == 2) begin
            get(inst, busy, rdy, err);
            chk($sformatf("inst%0d_busy_in_pilot", inst), busy, 1);
            chk($sformatf("inst%0d_ready_in_pilot", inst), rdy, 1);
         end
         if (!stall && k == p + 2) begin
            get(inst, busy, rdy, err);
            chk($sformatf("inst%0d_ready_in_wait", inst), rdy, 0);
         end
         drive(inst, (k == 0) || (k == ovr_k), stall ? ((k % 2) == 0) : 1'b1);
         step();
      end
      if (abort_k < done_k) begin
         reset = 1'b1;
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000 ns");
      $fatal(1);
   end

   initial begin
      int busy, rdy, err;
      reset = 1'b1;
      drive(0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0);
      step();
      step();
      // Reset state
      chk("rst_in_ready", int'(if0.in_ready), 0);
      chk("rst_ce_clear", int'(if0.ce_clear), 0);
      chk("rst_pilot_en", int'(if0.ce_pilot_en), 0);
      chk("rst_est_load", int'(if0.ce_est_load), 0);
      chk("rst_apply_en", int'(if0.ce_apply_en), 0);
      chk("rst_busy", int'(if0.busy), 0);
      chk("rst_frame_done", int'(if0.frame_done), 0);
      chk("rst_err", int'(if0.err_overrun), 0);
      chk("rst_sym_idx", int'(if0.sym_idx), 0);
      chk("rst_busy_b", int'(if1.busy), 0);
      reset = 1'b0;
      idle(3);
      chk("idle_still_idle", int'(if0.busy), 0);

      // Full-rate frame: clear 1, pilots 2..17, est 21, data 22..85, done 86
      frame(0, 1'b0, -1, NoAbort);
      idle(4);
      chk("full_err", int'(if0.err_overrun), 0);
      chk("full_queue_empty", q0.size(), 0);

      // Stalled input
      frame(0, 1'b1, -1, NoAbort);
      idle(4);
      chk("stall_queue_empty", q0.size(), 0);

      // Overrun: start at pilot sym_idx 5 (cycle 7); timing unchanged
      frame(0, 1'b0, 7, NoAbort);
      chk("ovr_err_set", int'(if0.err_overrun), 1);
      idle(4);
      chk("ovr_err_sticky", int'(if0.err_overrun), 1);
      chk("ovr_queue_empty", q0.size(), 0);
      reset = 1'b1;
      #1;
      chk("ovr_err_cleared_by_reset", int'(if0.err_overrun), 0);
      step();
      reset = 1'b0;
      idle(2);

      // Back-to-back: second start in the DONE cycle; done pulses 86 cycles apart
      frame(0, 1'b0, -1, NoAbort);
      frame(0, 1'b0, -1, NoAbort);
      idle(4);
      chk("b2b_err", int'(if0.err_overrun), 0);
      chk("b2b_queue_empty", q0.size(), 0);

      // Reset in DATA at sym_idx 30 (cycle 52)
      frame(0, 1'b0, -1, 52);
      chk("mid_rst_busy", int'(if0.busy), 0);
      chk("mid_rst_in_ready", int'(if0.in_ready), 0);
      chk("mid_rst_apply_en", int'(if0.ce_apply_en), 0);
      chk("mid_rst_sym_idx", int'(if0.sym_idx), 0);
      step();
      reset = 1'b0;
      chk("mid_rst_queue_empty", q0.size(), 0);
      idle(3);
      chk("mid_rst_stays_idle", int'(if0.busy), 0);
      frame(0, 1'b0, -1, NoAbort);
      idle(4);
      chk("post_rst_queue_empty", q0.size(), 0);

      // Boundary instance: est in cycle 3, data 4..259 idx 0..255, done 260
      frame(1, 1'b0, -1, NoAbort);
      idle(4);
      get(1, busy, rdy, err);
      chk("bnd_busy_after", busy, 0);
      chk("bnd_err", err, 0);
      chk("bnd_queue_empty", q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
